contador_programa: RTL and testbench

Program counter unit of the microprocessor: consumes the 2-bit PC-select code produced by the jump-decision stage (`Saltos`) and computes the next instruction address. Holds the PC register and a small return-address stack for subroutine call/return. Its registered address output drives the instruction memory.

---
 rtl/contador_programa.sv | 117 +++++++++++
 tb/tb_contador_programa.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/contador_programa.sv
`default_nettype none
// ============================================================================
// contador_programa : program counter with return-address stack
// Rev 1.0 - initial release
// ============================================================================
module contador_programa #(
  parameter int ANCHO_PC     = 8,
  parameter int ANCHO_OFFSET = 6,
  parameter int PILA_PROF    = 8,
  parameter logic [ANCHO_PC-1:0] VECTOR_RESET = '0
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset_n,
  input  logic                           i_Habilitar,
  input  logic [1:0]                     i_Salto_PC,
  input  logic                           i_Llamada,
  input  logic [ANCHO_PC-1:0]            i_Direccion,
  input  logic [ANCHO_OFFSET-1:0]        i_Offset,
  output logic [ANCHO_PC-1:0]            o_PC,
  output logic [$clog2(PILA_PROF):0]     o_Nivel_Pila,
  output logic                           o_Pila_Vacia,
  output logic                           o_Pila_Llena,
  output logic                           o_Error_Pila
);

  localparam int AW = $clog2(PILA_PROF);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] NIVEL_LLENO = NW'(PILA_PROF);

  localparam logic [1:0] SEL_SECUENCIAL = 2'b00;
  localparam logic [1:0] SEL_ABSOLUTO   = 2'b01;
  localparam logic [1:0] SEL_RELATIVO   = 2'b10;
  localparam logic [1:0] SEL_RETORNO    = 2'b11;

  logic [ANCHO_PC-1:0] pc_q, pc_d;
  logic [NW-1:0]       nivel_q, nivel_d;
  logic                error_q, error_d;
  logic                push;

  logic [ANCHO_PC-1:0] pila_q [PILA_PROF];

  logic [ANCHO_PC-1:0] w_pc_inc;
  logic [ANCHO_PC-1:0] w_offset_ext;
  logic [AW-1:0]       w_idx_push;
  logic [AW-1:0]       w_idx_pop;
  logic                w_vacia;
  logic                w_llena;

  assign w_pc_inc     = pc_q + {{(ANCHO_PC-1){1'b0}}, 1'b1};
  assign w_offset_ext = {{(ANCHO_PC-ANCHO_OFFSET){i_Offset[ANCHO_OFFSET-1]}}, i_Offset};
  assign w_vacia      = (nivel_q == '0);
  assign w_llena      = (nivel_q == NIVEL_LLENO);
  // Low bits only: pushes never happen when full, pops never when empty.
  assign w_idx_push   = nivel_q[AW-1:0];
  assign w_idx_pop    = nivel_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

  always_comb begin
    pc_d    = pc_q;
    nivel_d = nivel_q;
    error_d = error_q;
    push    = 1'b0;
    if (i_Habilitar) begin
      case (i_Salto_PC)
        SEL_SECUENCIAL: pc_d = w_pc_inc;
        SEL_ABSOLUTO: begin
          pc_d = i_Direccion;
          if (i_Llamada) begin
            if (w_llena) begin
              error_d = 1'b1;
            end else begin
              push    = 1'b1;
              nivel_d = nivel_q + {{(NW-1){1'b0}}, 1'b1};
            end
          end
        end
        SEL_RELATIVO: pc_d = pc_q + w_offset_ext;
        SEL_RETORNO: begin
          if (w_vacia) begin
            pc_d    = w_pc_inc;
            error_d = 1'b1;
          end else begin
            pc_d    = pila_q[w_idx_pop];
            nivel_d = nivel_q - {{(NW-1){1'b0}}, 1'b1};
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      pc_q    <= VECTOR_RESET;
      nivel_q <= '0;
      error_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      nivel_q <= nivel_d;
      error_q <= error_d;
    end
  end

  // Stack storage carries no reset; contents are meaningless while level is 0.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      pila_q[w_idx_push] <= w_pc_inc;
    end
  end

  assign o_PC         = pc_q;
  assign o_Nivel_Pila = nivel_q;
  assign o_Pila_Vacia = w_vacia;
  assign o_Pila_Llena = w_llena;
  assign o_Error_Pila = error_q;

endmodule
`default_nettype wire

// File: tb/tb_contador_programa.sv
`default_nettype none
// ============================================================================
// tb_contador_programa : directed self-checking bench for contador_programa
// Rev 1.0 - initial release
// ============================================================================
module tb_contador_programa;

  logic       clk;
  logic       rst_n;
  logic       hab;
  logic [1:0] sel;
  logic       llamada;
  logic [7:0] dir;
  logic [5:0] offset;
  logic [7:0] pc;
  logic [3:0] nivel;
  logic       vacia;
  logic       llena;
  logic       err;

  int compared   = 0;
  int mismatched = 0;

  contador_programa #(
    .ANCHO_PC     (8),
    .ANCHO_OFFSET (6),
    .PILA_PROF    (8),
    .VECTOR_RESET (8'h00)
  ) dut (
    .i_Clk        (clk),
    .i_Reset_n    (rst_n),
    .i_Habilitar  (hab),
    .i_Salto_PC   (sel),
    .i_Llamada    (llamada),
    .i_Direccion  (dir),
    .i_Offset     (offset),
    .o_PC         (pc),
    .o_Nivel_Pila (nivel),
    .o_Pila_Vacia (vacia),
    .o_Pila_Llena (llena),
    .o_Error_Pila (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic h, input logic [1:0] s, input logic l,
                      input logic [7:0] d, input logic [5:0] o);
    @(negedge clk);
    hab     = h;
    sel     = s;
    llamada = l;
    dir     = d;
    offset  = o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hab   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hab = 1'b0; sel = 2'b00; llamada = 1'b0; dir = 8'h00; offset = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 8'h00);
    chk("reset_nivel", nivel, 4'd0);
    chk("reset_vacia", vacia, 1'b1);
    chk("reset_llena", llena, 1'b0);
    chk("reset_error", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential run
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 2'b00, 1'b0, 8'h00, 6'h00);
      chk("seq_pc", pc, 32'(i));
    end
    chk("seq_vacia", vacia, 1'b1);
    chk("seq_error", err, 1'b0);

    // Call / return
    step(1'b1, 2'b01, 1'b0, 8'h10, 6'h00);
    chk("abs_pc", pc, 8'h10);
    chk("abs_nivel", nivel, 4'd0);
    step(1'b1, 2'b01, 1'b1, 8'h40, 6'h00);
    chk("call_pc", pc, 8'h40);
    chk("call_nivel", nivel, 4'd1);
    chk("call_vacia", vacia, 1'b0);
    step(1'b1, 2'b11, 1'b0, 8'h00, 6'h00);
    chk("ret_pc", pc, 8'h11);
    chk("ret_nivel", nivel, 4'd0);
    chk("ret_vacia", vacia, 1'b1);

    // Relative jumps and wrap
    step(1'b1, 2'b01, 1'b0, 8'h20, 6'h00);
    step(1'b1, 2'b10, 1'b1, 8'h00, 6'b111101);
    chk("rel_neg_pc", pc, 8'h1D);
    chk("rel_ignores_call", nivel, 4'd0);
    step(1'b1, 2'b01, 1'b0, 8'hFE, 6'h00);
    step(1'b1, 2'b10, 1'b0, 8'h00, 6'd5);
    chk("rel_wrap_pc", pc, 8'h03);
    step(1'b1, 2'b01, 1'b0, 8'h02, 6'h00);
    step(1'b1, 2'b10, 1'b0, 8'h00, 6'b111100);
    chk("rel_wrap_down_pc", pc, 8'hFE);
    step(1'b1, 2'b01, 1'b0, 8'hFF, 6'h00);
    step(1'b1, 2'b00, 1'b0, 8'h00, 6'h00);
    chk("seq_wrap_pc", pc, 8'h00);

    // Nine calls from PC 0x00: targets 0x80 + 8k; pushes 0x01, then previous target + 1
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 2'b01, 1'b1, 8'(8'h80 + 8 * k), 6'h00);
      chk("deep_call_pc", pc, 32'(8'h80 + 8 * k));
      if (k < 8) begin
        chk("deep_call_nivel", nivel, 32'(k + 1));
        chk("deep_call_error", err, 1'b0);
      end
    end
    chk("overflow_nivel", nivel, 4'd8);
    chk("overflow_llena", llena, 1'b1);
    chk("overflow_error", err, 1'b1);
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 2'b11, 1'b0, 8'h00, 6'h00);
      chk("deep_ret_pc", pc, (j == 7) ? 32'h01 : 32'(8'h80 + 8 * (6 - j) + 1));
      chk("deep_ret_nivel", nivel, 32'(7 - j));
      chk("deep_ret_llena", llena, 1'b0);
    end
    chk("deep_ret_vacia", vacia, 1'b1);

    // Underflow after a fresh reset
    do_reset();
    chk("rst2_error", err, 1'b0);
    chk("rst2_pc", pc, 8'h00);
    step(1'b1, 2'b01, 1'b0, 8'h30, 6'h00);
    step(1'b1, 2'b11, 1'b0, 8'h00, 6'h00);
    chk("underflow_pc", pc, 8'h31);
    chk("underflow_nivel", nivel, 4'd0);
    chk("underflow_error", err, 1'b1);
    step(1'b1, 2'b00, 1'b0, 8'h00, 6'h00);
    step(1'b1, 2'b00, 1'b0, 8'h00, 6'h00);
    chk("sticky_pc", pc, 8'h33);
    chk("sticky_error", err, 1'b1);

    // Stall with a call presented, then async reset mid-stall
    step(1'b1, 2'b01, 1'b1, 8'h60, 6'h00);
    chk("pre_stall_pc", pc, 8'h60);
    chk("pre_stall_nivel", nivel, 4'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b01, 1'b1, 8'h55, 6'h00);
      chk("stall_pc", pc, 8'h60);
      chk("stall_nivel", nivel, 4'd1);
    end
    step(1'b0, 2'b11, 1'b0, 8'h00, 6'h00);
    chk("stall_ret_pc", pc, 8'h60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 8'h00);
    chk("async_rst_nivel", nivel, 4'd0);
    chk("async_rst_vacia", vacia, 1'b1);
    chk("async_rst_error", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'b00, 1'b0, 8'h00, 6'h00);
    chk("post_rst_hold_pc", pc, 8'h00);
    step(1'b1, 2'b00, 1'b0, 8'h00, 6'h00);
    chk("post_rst_first_pc", pc, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
